// File: rtl/mat_addsub_path.sv
// Element-wise matrix add/sub/sat engine: LANES elements per beat over ELEMS/LANES beats.
// Latency BEATS+1 cycles from start to done; start is ignored while running (no backpressure).
module mat_addsub_path #(
  parameter int ELEM_W = 4,
  parameter int ELEMS  = 16,
  parameter int LANES  = 8,
  parameter int SLOT_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [ELEMS*ELEM_W-1:0]   mat_A,
  input  logic [ELEMS*ELEM_W-1:0]   mat_B,
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  output logic [ELEMS*SLOT_W-1:0]   mat_out
);

  localparam int BEATS = ELEMS / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (ELEMS % LANES != 0) begin : g_chk_lanes
      $error("mat_addsub_path: LANES must divide ELEMS");
    end
    if (SLOT_W < ELEM_W + 1) begin : g_chk_slot
      $error("mat_addsub_path: SLOT_W must be at least ELEM_W+1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [ELEMS*ELEM_W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]                mode_q, mode_d;
  logic [ELEMS*SLOT_W-1:0]   out_q, out_d;
  logic                      busy_q, busy_d, done_q, done_d, valid_q, valid_d;

  function automatic logic [SLOT_W-1:0] elem_op(input logic [ELEM_W-1:0] a,
                                                input logic [ELEM_W-1:0] b,
                                                input logic [1:0]        m);
    logic [ELEM_W:0]   sum;
    logic [ELEM_W:0]   diff;
    logic [SLOT_W-1:0] r;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    r    = '0;
    case (m)
      2'b00: r[ELEM_W:0] = sum;
      2'b01: begin
        // Sign-extend the (ELEM_W+1)-bit difference across the whole slot
        r          = {SLOT_W{diff[ELEM_W]}};
        r[ELEM_W:0] = diff;
      end
      2'b10:   r[ELEM_W-1:0] = sum[ELEM_W] ? {ELEM_W{1'b1}} : sum[ELEM_W-1:0];
      default: r[ELEM_W-1:0] = diff[ELEM_W] ? '0 : diff[ELEM_W-1:0];
    endcase
    return r;
  endfunction

  always_comb begin
    int idx;
    idx     = 0;
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    out_d   = out_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    case (state_q)
      RUN: begin
        for (int j = 0; j < LANES; j++) begin
          idx = int'(beat_q) * LANES + j;
          out_d[(ELEMS-1-idx)*SLOT_W +: SLOT_W] =
            elem_op(a_q[(ELEMS-1-idx)*ELEM_W +: ELEM_W],
                    b_q[(ELEMS-1-idx)*ELEM_W +: ELEM_W], mode_q);
        end
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = DONE;
          beat_d  = '0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          beat_d  = '0;
          a_d     = mat_A;
          b_d     = mat_B;
          mode_d  = mode;
          out_d   = '0;
          valid_d = 1'b0;
        end
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign mat_out   = out_q;

endmodule

// File: tb/tb_mat_addsub_path.sv
// Bench for mat_addsub_path: four parameter variants share stimulus and are checked
// every cycle against a timeline model of each accepted operation.
module tb_mat_addsub_path;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic [7:0] a_e[16];
  logic [7:0] b_e[16];

  logic [63:0]  a4, b4;
  logic [127:0] a8, b8;
  logic [3:0]   busy_v, done_v, ov_v;
  logic [159:0] out4[3];
  logic [191:0] out8;

  int vec = 0;
  int mis = 0;
  int cyc = 0;

  // Model state: per-variant accepted operation and its capture cycle
  int         n0[4];
  bit         have[4];
  logic [7:0] ma[4][16];
  logic [7:0] mb[4][16];
  int         mm[4];

  always #5 clk = ~clk;

  always_comb begin
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    for (int i = 0; i < 16; i++) begin
      a4[(15-i)*4 +: 4] = a_e[i][3:0];
      b4[(15-i)*4 +: 4] = b_e[i][3:0];
      a8[(15-i)*8 +: 8] = a_e[i];
      b8[(15-i)*8 +: 8] = b_e[i];
    end
  end

  mat_addsub_path #(.ELEM_W(4), .ELEMS(16), .LANES(8), .SLOT_W(10)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .mat_A(a4), .mat_B(b4),
    .busy(busy_v[0]), .done(done_v[0]), .out_valid(ov_v[0]), .mat_out(out4[0]));
  mat_addsub_path #(.ELEM_W(4), .ELEMS(16), .LANES(16), .SLOT_W(10)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .mat_A(a4), .mat_B(b4),
    .busy(busy_v[1]), .done(done_v[1]), .out_valid(ov_v[1]), .mat_out(out4[1]));
  mat_addsub_path #(.ELEM_W(4), .ELEMS(16), .LANES(1), .SLOT_W(10)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .mat_A(a4), .mat_B(b4),
    .busy(busy_v[2]), .done(done_v[2]), .out_valid(ov_v[2]), .mat_out(out4[2]));
  mat_addsub_path #(.ELEM_W(8), .ELEMS(16), .LANES(8), .SLOT_W(12)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .mat_A(a8), .mat_B(b8),
    .busy(busy_v[3]), .done(done_v[3]), .out_valid(ov_v[3]), .mat_out(out8));

  function automatic int ew(input int k); return (k == 3) ? 8 : 4; endfunction
  function automatic int sw(input int k); return (k == 3) ? 12 : 10; endfunction
  function automatic int bt(input int k);
    case (k)
      1:       return 1;
      2:       return 16;
      default: return 2;
    endcase
  endfunction
  function automatic int ln(input int k); return 16 / bt(k); endfunction

  function automatic int calc(input int a, input int b, input int m, input int w, input int s);
    int mx;
    mx = (1 << w) - 1;
    a  = a & mx;
    b  = b & mx;
    case (m)
      0:       return a + b;
      1:       return (a - b) & ((1 << s) - 1);
      2:       return (a + b > mx) ? mx : a + b;
      default: return (a < b) ? 0 : a - b;
    endcase
  endfunction

  function automatic logic [191:0] get_out(input int k);
    return (k == 3) ? out8 : {32'b0, out4[k]};
  endfunction

  function automatic int slot(input int k, input int i);
    logic [191:0] v;
    v = get_out(k) >> ((15 - i) * sw(k));
    return int'(v[11:0]) & ((1 << sw(k)) - 1);
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Accept a start only when the variant was not mid-run in the cycle before this edge
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start) begin
      for (int k = 0; k < 4; k++) begin
        if (!(have[k] && cyc - 1 >= n0[k] && cyc - 1 < n0[k] + bt(k))) begin
          have[k] = 1'b1;
          n0[k]   = cyc;
          mm[k]   = int'(mode);
          for (int i = 0; i < 16; i++) begin
            ma[k][i] = a_e[i];
            mb[k][i] = b_e[i];
          end
        end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 4; k++) have[k] = 1'b0;
  end

  always @(negedge clk) begin
    logic [191:0] e;
    logic [2:0]   ec;
    for (int k = 0; k < 4; k++) begin
      e  = '0;
      ec = '0;
      if (have[k]) begin
        ec[2] = (cyc >= n0[k] && cyc < n0[k] + bt(k));
        ec[1] = (cyc == n0[k] + bt(k));
        ec[0] = (cyc >= n0[k] + bt(k));
        for (int i = 0; i < 16; i++) begin
          if (cyc >= n0[k] + i / ln(k) + 1)
            e |= 192'(calc(int'(ma[k][i]), int'(mb[k][i]), mm[k], ew(k), sw(k))) << ((15 - i) * sw(k));
        end
      end
      chk($sformatf("ctrl u%0d cyc %0d", k, cyc), 192'({busy_v[k], done_v[k], ov_v[k]}), 192'(ec));
      chk($sformatf("mat_out u%0d cyc %0d", k, cyc), get_out(k), e);
    end
  end

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < 16; i++) begin
      a_e[i] = 8'(a);
      b_e[i] = 8'(b);
    end
  endtask

  task automatic pulse(input int m);
    @(negedge clk);
    mode  = 2'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (18) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin have[k] = 1'b0; n0[k] = 0; mm[k] = 0; end
    set_all(0, 0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add with defaults: busy in the two beat cycles, done in the third
    set_all(8'h0F, 8'h01);
    pulse(0);
    chk("add busy c1", 192'(busy_v[0]), 192'(1));
    chk("add done c1", 192'(done_v[0]), 192'(0));
    @(negedge clk);
    chk("add busy c2", 192'(busy_v[0]), 192'(1));
    @(negedge clk);
    chk("add done c3", 192'({busy_v[0], done_v[0], ov_v[0]}), 192'(3'b011));
    @(negedge clk);
    chk("add done c4", 192'({done_v[0], ov_v[0]}), 192'(2'b01));
    settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("add slot0 u%0d", k), 192'(slot(k, 0)), 192'(16));
      chk($sformatf("add slot15 u%0d", k), 192'(slot(k, 15)), 192'(16));
    end

    set_all(3, 5);   pulse(1); settle();
    chk("sub neg u0", 192'(slot(0, 7)), 192'(10'h3FE));
    chk("sub neg u3", 192'(slot(3, 7)), 192'(12'hFFE));
    set_all(5, 3);   pulse(1); settle();
    chk("sub pos", 192'(slot(0, 9)), 192'(2));
    set_all(8'h0C, 8'h07); pulse(2); settle();
    chk("add sat", 192'(slot(0, 4)), 192'(10'h00F));
    pulse(0); settle();
    chk("add nosat", 192'(slot(0, 4)), 192'(10'h013));
    set_all(2, 9);   pulse(3); settle();
    chk("sub sat", 192'(slot(0, 12)), 192'(0));

    // Ordering and beat staging
    for (int i = 0; i < 16; i++) begin a_e[i] = 8'(i); b_e[i] = 8'h00; end
    pulse(0);
    @(negedge clk);
    chk("stage slot3", 192'(slot(0, 3)), 192'(3));
    chk("stage slot10", 192'(slot(0, 10)), 192'(0));
    settle();
    chk("order slot10", 192'(slot(0, 10)), 192'(10));
    chk("order slot15 u2", 192'(slot(2, 15)), 192'(15));

    // Operand change and stray start during RUN
    set_all(1, 2);
    pulse(0);
    set_all(7, 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    settle();
    chk("isolate u0", 192'(slot(0, 5)), 192'(3));
    chk("isolate u2", 192'(slot(2, 5)), 192'(3));

    // Start in the done cycle
    set_all(4, 4);
    pulse(0);
    @(negedge clk);
    @(negedge clk);
    chk("restart done", 192'(done_v[0]), 192'(1));
    set_all(1, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart ctrl", 192'({busy_v[0], done_v[0], ov_v[0]}), 192'(3'b100));
    chk("restart clr", get_out(0), 192'(0));
    @(negedge clk);
    @(negedge clk);
    chk("restart done2", 192'(done_v[0]), 192'(1));
    chk("restart res", 192'(slot(0, 0)), 192'(2));
    settle();

    // Asynchronous reset during beat 1
    set_all(9, 3);
    pulse(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", 192'(busy_v), 192'(0));
    chk("rst flags", 192'({done_v, ov_v}), 192'(0));
    chk("rst out", get_out(0), 192'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post rst idle", 192'({busy_v, ov_v}), 192'(0));

    // Random operands, modes and start timing
    repeat (800) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        a_e[i] = 8'($urandom_range(0, 255));
        b_e[i] = 8'($urandom_range(0, 255));
      end
      mode  = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
